iob_clk_meter: RTL
==================

Name: iob_clk_meter

Overview:
- Measures the average period of an asynchronous periodic input (e.g. an NCO output) in units of the system clock.
- Output is unsigned fixed point with FRAC_W fractional bits, the same format as the NCO period CSR. A 18.5-cycle input reads 16'h1280.
- Serves as the receive-side counterpart of the NCO: it recovers the programmed period from the generated clock.
- Used as a standalone core or behind a CSR wrapper for loopback self-test.

Parameters:
- PERIOD_W, 16, width of the period counter and period_o; integer part is PERIOD_W-FRAC_W bits.
- FRAC_W, 8, fractional bits; averaging window is 2^FRAC_W input periods. Must satisfy 1 <= FRAC_W < PERIOD_W.

Ports:
- clk_i  in  1  system clock.
- cke_i  in  1  clock enable; when 0, all registers hold.
- arst_i  in  1  asynchronous reset, active-high.
- soft_reset_i  in  1  synchronous reset; same effect as arst_i, applied at the next clock edge.
- en_i  in  1  measurement enable.
- sig_i  in  1  measured signal, asynchronous to clk_i.
- period_o  out  PERIOD_W  last measured period (fixed point).
- valid_o  out  1  one-cycle pulse when period_o is updated.
- overflow_o  out  1  one-cycle pulse, together with valid_o, when the window saturated.

Behaviour:
- Reset (arst_i or soft_reset_i): period_o=0, valid_o=0, overflow_o=0, cnt=0, edge_cnt=0, sync regs=0, state=IDLE.
- sig_i path: two-flop synchronizer, then an edge-detect flop. A rising edge is detected 3 enabled cycles after it is sampled. The latency is constant, so it cancels in the measurement.
- State IDLE: counters cleared. Go to ARM when en_i=1.
- State ARM: wait for a detected rising edge. On the edge: cnt<=1, edge_cnt<=0, go to MEASURE.
- State MEASURE, each enabled cycle:
  - Detected edge with edge_cnt==2^FRAC_W-1 (window end): period_o<=cnt, valid_o pulses, cnt<=1, edge_cnt<=0, stay in MEASURE. Measurement is back-to-back with no dead cycles.
  - Detected edge otherwise: edge_cnt++, cnt++.
  - No edge and cnt==2^PERIOD_W-1 (saturation): period_o<=all ones, valid_o and overflow_o pulse, go to ARM. This covers a stopped input or one that is too slow.
  - Otherwise: cnt++.
- Result: for a constant input period P, period_o = P*2^FRAC_W. A jittered input yields the truncated mean.
- Window end and saturation in the same cycle: window end wins, period_o=all ones with overflow_o=0.
- en_i dropping in any state: go to IDLE next cycle. The partial window is discarded; period_o is held and no pulse is emitted.
- Reset mid-window: the partial window is discarded and all outputs return to their reset values.
- cke_i=0: all state holds, including synchronizer and pulses; a pulse is not repeated.
- valid_o and overflow_o are registered and never high for more than one enabled cycle.
- Input high or low time below 2 clk cycles is unsupported; edges may be missed.

Optional Feature:
- Macro: IOB_CLK_METER_DUTY_EN.
- Defined:
  - Adds output high_o (out, PERIOD_W): count of cycles in the window where the synchronized sig_i=1.
  - high_o uses the same scaling and update timing as period_o; duty cycle = high_o/period_o.
  - The high counter saturates with cnt.
  - On overflow, high_o<=all ones; reset value 0.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic period: reset, en_i=1, sig_i square wave of 20 clk (10 high/10 low) -> first valid_o about 256*20 cycles after the arm edge, period_o=16'h1400, overflow_o=0; later windows repeat exactly every 5120 cycles.
- Fractional period: sig_i periods alternating 18/19 clk (NCO loopback, 16'h1280) -> period_o=16'h1280 every window.
- Stopped input: sig_i held low after arming -> valid_o and overflow_o pulse together after 65535 counts, period_o=16'hFFFF, FSM returns to ARM. Restarting sig_i at period 20 -> 16'h1400.
- Disable and soft reset: en_i=0 mid-window -> no pulse, period_o holds the previous value. soft_reset_i=1 -> period_o=0. Re-enable -> first result after a full window.
- cke_i gating: cke_i toggling 1/0 every cycle with sig_i period 40 clk -> period_o=16'h1400 (20 enabled cycles per period).
- Duty (IOB_CLK_METER_DUTY_EN): period 20 with 5 high -> period_o=16'h1400, high_o=16'h0500.

Source files
------------

// File: rtl/iob_clk_meter.sv
// iob_clk_meter: measures the average period of an asynchronous periodic input
// in system-clock cycles, as unsigned fixed point with FRAC_W fractional bits.
// The averaging window is 2^FRAC_W input periods, so the window length in
// cycles is already the fixed-point period.
// Optional feature macro: IOB_CLK_METER_DUTY_EN adds high_o, the number of
// window cycles with the synchronized input high (same scaling as period_o).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | counters cleared, waiting for en_i
// ARM      | waiting for the first detected rising edge of a window
// MEASURE  | counting cycles and edges; publishes at window end or saturation
module iob_clk_meter #(
  parameter int PERIOD_W = 16,
  parameter int FRAC_W   = 8
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                soft_reset_i,
  input  logic                en_i,
  input  logic                sig_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic                valid_o,
  output logic                overflow_o
`ifdef IOB_CLK_METER_DUTY_EN
  ,
  output logic [PERIOD_W-1:0] high_o
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  logic                sync1_q, sync2_q, sig_prev_q;
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [FRAC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;

  logic sig_rise, win_end, cnt_max;
  logic clear_s, restart_s, bump_s, edge_inc_s, done_s, sat_s;

  assign sig_rise = sync2_q & ~sig_prev_q;
  assign win_end  = &edge_cnt_q;
  assign cnt_max  = &cnt_q;
  // The cycle counter sticks at all ones so a late edge cannot wrap it.
  assign cnt_inc  = cnt_max ? cnt_q : cnt_q + PERIOD_W'(1);

  // FSM: decide next state and which counter action applies this cycle.
  always_comb begin
    state_d    = state_q;
    clear_s    = 1'b0;
    restart_s  = 1'b0;
    bump_s     = 1'b0;
    edge_inc_s = 1'b0;
    done_s     = 1'b0;
    sat_s      = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      clear_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clear_s = 1'b1;
          state_d = ARM;
        end
        ARM: begin
          if (sig_rise) begin
            restart_s = 1'b1;
            state_d   = MEASURE;
          end
        end
        MEASURE: begin
          // Window end takes priority over saturation in the same cycle.
          if (sig_rise && win_end) begin
            done_s    = 1'b1;
            restart_s = 1'b1;
          end else if (sig_rise) begin
            bump_s     = 1'b1;
            edge_inc_s = 1'b1;
          end else if (cnt_max) begin
            sat_s   = 1'b1;
            state_d = ARM;
          end else begin
            bump_s = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  // Datapath: counters and published result driven by the FSM strobes.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_s)        cnt_d = '0;
    else if (restart_s) cnt_d = PERIOD_W'(1);
    else if (bump_s)    cnt_d = cnt_inc;

    edge_cnt_d = edge_cnt_q;
    if (clear_s || restart_s) edge_cnt_d = '0;
    else if (edge_inc_s)      edge_cnt_d = edge_cnt_q + FRAC_W'(1);

    period_d = period_q;
    if (done_s)     period_d = cnt_q;
    else if (sat_s) period_d = '1;

    valid_d    = done_s | sat_s;
    overflow_d = sat_s;
  end

  // State registers, synchronizer and result; cke_i freezes everything.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sig_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (cke_i) begin
      if (soft_reset_i) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        sig_prev_q <= 1'b0;
        state_q    <= IDLE;
        cnt_q      <= '0;
        edge_cnt_q <= '0;
        period_q   <= '0;
        valid_q    <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        sync1_q    <= sig_i;
        sync2_q    <= sync1_q;
        sig_prev_q <= sync2_q;
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        edge_cnt_q <= edge_cnt_d;
        period_q   <= period_d;
        valid_q    <= valid_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign period_o   = period_q;
  assign valid_o    = valid_q;
  assign overflow_o = overflow_q;

`ifdef IOB_CLK_METER_DUTY_EN
  logic [PERIOD_W-1:0] high_cnt_q, high_cnt_d;
  logic [PERIOD_W-1:0] high_q, high_d;

  // High-time counter follows the cycle counter; the window starts on an
  // edge cycle, which is itself a high cycle.
  always_comb begin
    high_cnt_d = high_cnt_q;
    if (clear_s)        high_cnt_d = '0;
    else if (restart_s) high_cnt_d = PERIOD_W'(sync2_q);
    else if (bump_s && sync2_q && !(&high_cnt_q))
      high_cnt_d = high_cnt_q + PERIOD_W'(1);

    high_d = high_q;
    if (done_s)     high_d = high_cnt_q;
    else if (sat_s) high_d = '1;
  end

  // High-time registers share the reset and clock-enable rules.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      high_cnt_q <= '0;
      high_q     <= '0;
    end else if (cke_i) begin
      if (soft_reset_i) begin
        high_cnt_q <= '0;
        high_q     <= '0;
      end else begin
        high_cnt_q <= high_cnt_d;
        high_q     <= high_d;
      end
    end
  end

  assign high_o = high_q;
`endif

endmodule
